// File: rtl/frame_pacer_pkg.sv
// Shared encodings and defaults for the multi-channel frame pacer.
package frame_pacer_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } ch_state_e;

  localparam logic MODE_PERIODIC = 1'b0;
  localparam logic MODE_ONESHOT  = 1'b1;
  localparam int   DEF_CNT_W     = 4;
endpackage

// File: rtl/frame_pacer_ch.sv
// One pacer channel: divides frame_tick by (latched period + 1), periodic or one-shot.
module frame_pacer_ch
  import frame_pacer_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             frame_tick,
  input  logic             start,
  input  logic             stop,
  input  logic             one_shot,
  input  logic [CNT_W-1:0] period,
  output logic             tick,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] frame_count
);

  ch_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, per_q, per_d;
  logic             mode_q, mode_d;
  logic             tick_d, busy_d, done_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      per_q   <= '0;
      mode_q  <= MODE_PERIODIC;
      tick    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      per_q   <= per_d;
      mode_q  <= mode_d;
      tick    <= tick_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

  // stop > start > frame_tick; a start swallows any coincident frame_tick
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    per_d   = per_q;
    mode_d  = mode_q;
    tick_d  = 1'b0;
    busy_d  = busy;
    done_d  = done;
    if (stop) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
    end else if (start) begin
      state_d = ST_RUN;
      cnt_d   = '0;
      per_d   = period;
      mode_d  = one_shot;
      busy_d  = 1'b1;
      done_d  = 1'b0;
    end else if (state_q == ST_RUN && frame_tick) begin
      if (cnt_q == per_q) begin
        tick_d = 1'b1;
        cnt_d  = '0;
        if (mode_q == MODE_ONESHOT) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          per_d = period;
        end
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign frame_count = cnt_q;

endmodule

// File: rtl/frame_pacer.sv
// NUM_CH independent pacer channels driven from one shared frame strobe.
module frame_pacer
  import frame_pacer_pkg::*;
#(
  parameter int CNT_W  = DEF_CNT_W,
  parameter int NUM_CH = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    frame_tick,
  input  logic [NUM_CH-1:0]       start,
  input  logic [NUM_CH-1:0]       stop,
  input  logic [NUM_CH-1:0]       one_shot,
  input  logic [NUM_CH*CNT_W-1:0] period,
  output logic [NUM_CH-1:0]       tick,
  output logic [NUM_CH-1:0]       busy,
  output logic [NUM_CH-1:0]       done,
  output logic [NUM_CH*CNT_W-1:0] frame_count
);

  logic [NUM_CH-1:0][CNT_W-1:0] per_a, cnt_a;

  assign per_a       = period;
  assign frame_count = cnt_a;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    frame_pacer_ch #(.CNT_W(CNT_W)) u_ch (
      .clk         (clk),
      .reset       (reset),
      .frame_tick  (frame_tick),
      .start       (start[gi]),
      .stop        (stop[gi]),
      .one_shot    (one_shot[gi]),
      .period      (per_a[gi]),
      .tick        (tick[gi]),
      .busy        (busy[gi]),
      .done        (done[gi]),
      .frame_count (cnt_a[gi])
    );
  end

endmodule

// File: tb/tb_frame_pacer.sv
// Directed bench for frame_pacer with a per-cycle reference model and literal spot checks.
module tb_frame_pacer;
  localparam int CNT_W  = 4;
  localparam int NUM_CH = 2;

  logic                    clk = 1'b0;
  logic                    reset = 1'b1;
  logic                    frame_tick = 1'b0;
  logic [NUM_CH-1:0]       start = '0;
  logic [NUM_CH-1:0]       stop = '0;
  logic [NUM_CH-1:0]       one_shot = '0;
  logic [NUM_CH*CNT_W-1:0] period = '0;
  logic [NUM_CH-1:0]       tick, busy, done;
  logic [NUM_CH*CNT_W-1:0] frame_count;

  int checks = 0;
  int errors = 0;
  int tick_cnt [NUM_CH];

  frame_pacer #(.CNT_W(CNT_W), .NUM_CH(NUM_CH)) dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .start(start), .stop(stop),
    .one_shot(one_shot), .period(period), .tick(tick), .busy(busy), .done(done),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: a running channel emits one tick per (P+1) counted frames;
  // 'seen' is the number of frames counted in the current interval.
  int m_seen [NUM_CH];
  int m_p    [NUM_CH];
  bit m_os   [NUM_CH];
  bit m_on   [NUM_CH];
  bit m_done [NUM_CH];
  bit m_tick [NUM_CH];

  always @(posedge clk or posedge reset) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (reset) begin
        m_seen[c] <= 0; m_p[c] <= 0; m_os[c] <= 0;
        m_on[c] <= 0; m_done[c] <= 0; m_tick[c] <= 0;
      end else begin
        m_tick[c] <= 0;
        if (stop[c]) begin
          m_on[c] <= 0; m_done[c] <= 0; m_seen[c] <= 0;
        end else if (start[c]) begin
          m_on[c] <= 1; m_done[c] <= 0; m_seen[c] <= 0;
          m_p[c] <= int'(period[c*CNT_W +: CNT_W]);
          m_os[c] <= one_shot[c];
        end else if (m_on[c] && frame_tick) begin
          if ((m_seen[c] + 1) % (m_p[c] + 1) == 0) begin
            m_tick[c] <= 1;
            m_seen[c] <= 0;
            if (m_os[c]) begin
              m_on[c] <= 0; m_done[c] <= 1;
            end else begin
              m_p[c] <= int'(period[c*CNT_W +: CNT_W]);
            end
          end else begin
            m_seen[c] <= m_seen[c] + 1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      check($sformatf("model_tick%0d", c), int'(tick[c]), int'(m_tick[c]));
      check($sformatf("model_busy%0d", c), int'(busy[c]), int'(m_on[c]));
      check($sformatf("model_done%0d", c), int'(done[c]), int'(m_done[c]));
      check($sformatf("model_cnt%0d", c), int'(frame_count[c*CNT_W +: CNT_W]), m_seen[c]);
      if (tick[c] === 1'b1) tick_cnt[c] <= tick_cnt[c] + 1;
    end
  end

  initial for (int c = 0; c < NUM_CH; c++) tick_cnt[c] = 0;

  task automatic step(input logic ft, input logic [NUM_CH-1:0] st, input logic [NUM_CH-1:0] sp);
    frame_tick = ft; start = st; stop = sp;
    @(posedge clk); #2;
    frame_tick = 1'b0; start = '0; stop = '0;
  endtask

  task automatic frames(input int n);
    for (int k = 0; k < n; k++) begin
      step(1'b1, '0, '0);
      step(1'b0, '0, '0);
    end
  endtask

  initial begin
    int t0, t1;
    repeat (2) @(posedge clk);
    #2;
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_cnt", int'(frame_count), 0);
    reset = 1'b0;
    step(0, '0, '0);

    // mid-run reset with count 3
    period[3:0] = 4'd5;
    step(0, 2'b01, '0);
    frames(3);
    check("pre_reset_cnt", int'(frame_count[3:0]), 3);
    reset = 1'b1;
    #1;
    check("async_reset_busy", int'(busy), 0);
    check("async_reset_cnt", int'(frame_count), 0);
    check("async_reset_tick", int'(tick), 0);
    @(posedge clk); #2;
    reset = 1'b0;
    t0 = tick_cnt[0];
    frames(8);
    check("idle_no_tick", tick_cnt[0] - t0, 0);

    // periodic, P=3
    period[3:0] = 4'd3; one_shot = '0;
    step(0, 2'b01, '0);
    t0 = tick_cnt[0];
    for (int k = 1; k <= 12; k++) begin
      step(1, '0, '0);
      check("per_tick", int'(tick[0]), (k % 4 == 0) ? 1 : 0);
      check("per_cnt", int'(frame_count[3:0]), k % 4);
      check("per_busy", int'(busy[0]), 1);
      step(0, '0, '0);
    end
    check("per_total", tick_cnt[0] - t0, 3);
    step(0, 2'b01 ^ 2'b00, 2'b01);

    // one-shot ch1 with mid-run period change
    period[7:4] = 4'd2; one_shot = 2'b10;
    step(0, 2'b10, '0);
    one_shot = '0;
    t1 = tick_cnt[1];
    frames(1);
    period[7:4] = 4'd7;
    step(1, '0, '0);
    check("os_no_tick2", int'(tick[1]), 0);
    step(0, '0, '0);
    step(1, '0, '0);
    check("os_tick3", int'(tick[1]), 1);
    check("os_done", int'(done[1]), 1);
    check("os_busy", int'(busy[1]), 0);
    step(0, '0, '0);
    frames(4);
    check("os_single", tick_cnt[1] - t1, 1);
    check("os_done_hold", int'(done[1]), 1);
    step(0, 2'b10, '0);
    check("os_restart_done", int'(done[1]), 0);
    check("os_restart_busy", int'(busy[1]), 1);
    step(0, '0, 2'b10);

    // priority on ch0, P=1
    period[3:0] = 4'd1;
    step(0, 2'b01, '0);
    frames(1);
    check("pri_cnt1", int'(frame_count[3:0]), 1);
    step(1, '0, 2'b01);
    check("pri_stop_tick", int'(tick[0]), 0);
    check("pri_stop_busy", int'(busy[0]), 0);
    check("pri_stop_cnt", int'(frame_count[3:0]), 0);
    step(0, 2'b01, '0);
    frames(1);
    step(1, 2'b01, '0);
    check("pri_start_tick", int'(tick[0]), 0);
    check("pri_start_cnt", int'(frame_count[3:0]), 0);
    check("pri_start_busy", int'(busy[0]), 1);
    step(0, 2'b01, 2'b01);
    check("pri_both_busy", int'(busy[0]), 0);

    // boundaries: P=0 then P=15
    period[3:0] = 4'd0;
    step(0, 2'b01, '0);
    for (int k = 1; k <= 3; k++) begin
      step(1, '0, '0);
      check("p0_tick", int'(tick[0]), 1);
      step(0, '0, '0);
    end
    period[3:0] = 4'd15;
    step(0, 2'b01, '0);
    for (int k = 1; k <= 16; k++) begin
      step(1, '0, '0);
      check("p15_tick", int'(tick[0]), (k == 16) ? 1 : 0);
      check("p15_cnt", int'(frame_count[3:0]), k % 16);
      step(0, '0, '0);
    end
    step(0, '0, 2'b11);

    // independence, start coincident with frame_tick is not counted
    period = {4'd2, 4'd1}; one_shot = '0;
    step(1, 2'b11, '0);
    check("ind_start_cnt", int'(frame_count), 0);
    for (int k = 1; k <= 6; k++) begin
      step(1, '0, '0);
      check("ind_tick0", int'(tick[0]), (k % 2 == 0) ? 1 : 0);
      check("ind_tick1", int'(tick[1]), (k % 3 == 0) ? 1 : 0);
      if (k == 6) check("ind_both", int'(tick), 3);
      step(0, '0, '0);
    end
    step(0, '0, 2'b11);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
